id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_id_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage -- instruction decode stage of a simple in-order pipeline.
//
// Holds the IF/ID pipeline register, a 32x32 register file, the decoder,
// load-use / branch-operand hazard detection, branch/jump resolution and the
// ID/EX pipeline register that feeds the execute stage.
//
// Ports
//   clk, rst_n           : rising-edge clock, asynchronous active-low reset
//   PC, IR               : fetched word-address PC and instruction
//   IsStall              : hold fetch / IF/ID this cycle (hazard)
//   IsBranch, BranchAddr : redirect fetch to BranchAddr (0 when not taken)
//   WbEn/WbAddr/WbData   : register-file write port from writeback
//   MemRd, MemRegWrite   : destination of the instruction in the memory stage
//   Ex*                  : registered ID/EX outputs to execute
//
// Instruction fields: op[31:26] rd[25:21] rs1[20:16] rs2[15:11] funct[5:0]
// imm16[15:0]. Opcodes: 0 NOP, 1 ALU, 2 ADDI, 3 LOAD, 4 STORE, 5 BEQ, 6 JMP;
// every other opcode decodes as NOP. A NOP (including the IR=0 bubble) is
// issued to execute as ExValid=0.
//
// ExA carries read port A (rs1). ExB carries read port B, which reads rd for
// STORE/BEQ and rs2 otherwise. ExImm is the sign-extended imm16. ExRd is the
// destination only for register-writing instructions (ALU/ADDI/LOAD), else 0.
// ExOp is funct[3:0] for ALU and 0 (add) for everything else.
//
// Build option
//   WB_BYPASS_EN : when defined, a read of the register being written this
//                  cycle (WbEn=1, WbAddr!=0) returns WbData on both read ports
//                  and in the branch comparison. When undefined the old value
//                  is returned and the new value is visible next cycle.
// -----------------------------------------------------------------------------
module id_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-3:0] PC,
  input  logic [31:0]      IR,
  output logic             IsStall,
  output logic             IsBranch,
  output logic [WIDTH-3:0] BranchAddr,
  input  logic             WbEn,
  input  logic [4:0]       WbAddr,
  input  logic [WIDTH-1:0] WbData,
  input  logic [4:0]       MemRd,
  input  logic             MemRegWrite,
  output logic             ExValid,
  output logic [WIDTH-3:0] ExPC,
  output logic [3:0]       ExOp,
  output logic [WIDTH-1:0] ExA,
  output logic [WIDTH-1:0] ExB,
  output logic [WIDTH-1:0] ExImm,
  output logic [4:0]       ExRd,
  output logic             ExRegWrite,
  output logic             ExMemRead,
  output logic             ExMemWrite
);

  localparam int PW = WIDTH - 2;

  typedef enum logic [5:0] {
    OP_NOP   = 6'h00,
    OP_ALU   = 6'h01,
    OP_ADDI  = 6'h02,
    OP_LOAD  = 6'h03,
    OP_STORE = 6'h04,
    OP_BEQ   = 6'h05,
    OP_JMP   = 6'h06
  } opcode_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PW-1:0]    ifid_pc_q, ifid_pc_d;
  logic [31:0]      ifid_ir_q, ifid_ir_d;

  logic [WIDTH-1:0] rf_q [32];
  logic [WIDTH-1:0] rf_d [32];

  logic             ex_valid_q, ex_valid_d;
  logic [PW-1:0]    ex_pc_q, ex_pc_d;
  logic [3:0]       ex_op_q, ex_op_d;
  logic [WIDTH-1:0] ex_a_q, ex_a_d;
  logic [WIDTH-1:0] ex_b_q, ex_b_d;
  logic [WIDTH-1:0] ex_imm_q, ex_imm_d;
  logic [4:0]       ex_rd_q, ex_rd_d;
  logic             ex_reg_write_q, ex_reg_write_d;
  logic             ex_mem_read_q, ex_mem_read_d;
  logic             ex_mem_write_q, ex_mem_write_d;

  // ---------------------------------------------------------------------------
  // Field extraction
  // ---------------------------------------------------------------------------
  logic [5:0]       op;
  logic [4:0]       f_rd, f_rs1, f_rs2;
  logic [WIDTH-1:0] imm_x;
  logic [PW-1:0]    imm_pc;

  assign op     = ifid_ir_q[31:26];
  assign f_rd   = ifid_ir_q[25:21];
  assign f_rs1  = ifid_ir_q[20:16];
  assign f_rs2  = ifid_ir_q[15:11];
  assign imm_x  = {{(WIDTH-16){ifid_ir_q[15]}}, ifid_ir_q[15:0]};
  assign imm_pc = {{(PW-16){ifid_ir_q[15]}}, ifid_ir_q[15:0]};

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic       dec_valid;
  logic       dec_reg_write, dec_mem_read, dec_mem_write;
  logic       dec_is_beq, dec_is_jmp;
  logic       use_rs1, use_rs2, use_rd;
  logic [3:0] dec_op;

  always_comb begin
    dec_valid     = 1'b0;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_is_beq    = 1'b0;
    dec_is_jmp    = 1'b0;
    use_rs1       = 1'b0;
    use_rs2       = 1'b0;
    use_rd        = 1'b0;
    dec_op        = 4'h0;
    case (op)
      OP_ALU: begin
        dec_valid     = 1'b1;
        dec_reg_write = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        dec_op        = ifid_ir_q[3:0];
      end
      OP_ADDI: begin
        dec_valid     = 1'b1;
        dec_reg_write = 1'b1;
        use_rs1       = 1'b1;
      end
      OP_LOAD: begin
        dec_valid     = 1'b1;
        dec_reg_write = 1'b1;
        dec_mem_read  = 1'b1;
        use_rs1       = 1'b1;
      end
      OP_STORE: begin
        dec_valid     = 1'b1;
        dec_mem_write = 1'b1;
        use_rs1       = 1'b1;
        use_rd        = 1'b1;
      end
      OP_BEQ: begin
        dec_valid  = 1'b1;
        dec_is_beq = 1'b1;
        use_rs1    = 1'b1;
        use_rd     = 1'b1;
      end
      OP_JMP: begin
        dec_valid  = 1'b1;
        dec_is_jmp = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register file: two combinational read ports. Port B reads rd for the
  // instructions that use rd as a source, so BEQ compares port B with port A.
  // ---------------------------------------------------------------------------
  logic [4:0]       rd_a_addr, rd_b_addr;
  logic [WIDTH-1:0] rd_a, rd_b;

  assign rd_a_addr = f_rs1;
  assign rd_b_addr = use_rd ? f_rd : f_rs2;

  always_comb begin
    rd_a = (rd_a_addr == 5'd0) ? '0 : rf_q[rd_a_addr];
    rd_b = (rd_b_addr == 5'd0) ? '0 : rf_q[rd_b_addr];
`ifdef WB_BYPASS_EN
    if (WbEn && (WbAddr != 5'd0) && (WbAddr == rd_a_addr)) rd_a = WbData;
    if (WbEn && (WbAddr != 5'd0) && (WbAddr == rd_b_addr)) rd_b = WbData;
`endif
  end

  always_comb begin
    rf_d = rf_q;
    if (WbEn && (WbAddr != 5'd0)) rf_d[WbAddr] = WbData;
  end

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  logic load_use_hit, branch_op_hit;

  function automatic logic fwd_pending(input logic [4:0] r,
                                       input logic       ex_w,
                                       input logic [4:0] ex_rd,
                                       input logic       mem_w,
                                       input logic [4:0] mem_rd);
    return (r != 5'd0) && ((ex_w && (r == ex_rd)) || (mem_w && (r == mem_rd)));
  endfunction

  always_comb begin
    load_use_hit = ex_valid_q && ex_mem_read_q && (ex_rd_q != 5'd0) &&
                   ((use_rs1 && (f_rs1 == ex_rd_q)) ||
                    (use_rs2 && (f_rs2 == ex_rd_q)) ||
                    (use_rd  && (f_rd  == ex_rd_q)));
    // BEQ resolves here, so any in-flight producer of its operands stalls it.
    branch_op_hit = dec_is_beq &&
                    (fwd_pending(f_rd,  ex_reg_write_q, ex_rd_q, MemRegWrite, MemRd) ||
                     fwd_pending(f_rs1, ex_reg_write_q, ex_rd_q, MemRegWrite, MemRd));
  end

  // ---------------------------------------------------------------------------
  // Branch resolution (targets wrap modulo 2^PW)
  // ---------------------------------------------------------------------------
  logic [PW-1:0] beq_target, jmp_target;
  logic          taken;

  assign beq_target = ifid_pc_q + PW'(1) + imm_pc;
  assign jmp_target = {ifid_pc_q[PW-1:26], ifid_ir_q[25:0]};

  always_comb begin
    IsStall    = rst_n && (load_use_hit || branch_op_hit);
    taken      = dec_is_jmp || (dec_is_beq && (rd_a == rd_b));
    IsBranch   = rst_n && !IsStall && taken;
    BranchAddr = '0;
    if (IsBranch) BranchAddr = dec_is_jmp ? jmp_target : beq_target;
  end

  // ---------------------------------------------------------------------------
  // Next-state for IF/ID and ID/EX
  // ---------------------------------------------------------------------------
  always_comb begin
    ifid_pc_d = ifid_pc_q;
    ifid_ir_d = ifid_ir_q;
    if (!IsStall) begin
      ifid_pc_d = PC;
      ifid_ir_d = IsBranch ? 32'h0 : IR;
    end
  end

  always_comb begin
    ex_valid_d     = 1'b0;
    ex_pc_d        = '0;
    ex_op_d        = 4'h0;
    ex_a_d         = '0;
    ex_b_d         = '0;
    ex_imm_d       = '0;
    ex_rd_d        = 5'd0;
    ex_reg_write_d = 1'b0;
    ex_mem_read_d  = 1'b0;
    ex_mem_write_d = 1'b0;
    if (!IsStall && dec_valid) begin
      ex_valid_d     = 1'b1;
      ex_pc_d        = ifid_pc_q;
      ex_op_d        = dec_op;
      ex_a_d         = rd_a;
      ex_b_d         = rd_b;
      ex_imm_d       = imm_x;
      ex_rd_d        = dec_reg_write ? f_rd : 5'd0;
      ex_reg_write_d = dec_reg_write;
      ex_mem_read_d  = dec_mem_read;
      ex_mem_write_d = dec_mem_write;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_pc_q      <= '0;
      ifid_ir_q      <= '0;
      ex_valid_q     <= 1'b0;
      ex_pc_q        <= '0;
      ex_op_q        <= 4'h0;
      ex_a_q         <= '0;
      ex_b_q         <= '0;
      ex_imm_q       <= '0;
      ex_rd_q        <= 5'd0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_mem_write_q <= 1'b0;
    end else begin
      ifid_pc_q      <= ifid_pc_d;
      ifid_ir_q      <= ifid_ir_d;
      ex_valid_q     <= ex_valid_d;
      ex_pc_q        <= ex_pc_d;
      ex_op_q        <= ex_op_d;
      ex_a_q         <= ex_a_d;
      ex_b_q         <= ex_b_d;
      ex_imm_q       <= ex_imm_d;
      ex_rd_q        <= ex_rd_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_mem_write_q <= ex_mem_write_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  assign ExValid    = ex_valid_q;
  assign ExPC       = ex_pc_q;
  assign ExOp       = ex_op_q;
  assign ExA        = ex_a_q;
  assign ExB        = ex_b_q;
  assign ExImm      = ex_imm_q;
  assign ExRd       = ex_rd_q;
  assign ExRegWrite = ex_reg_write_q;
  assign ExMemRead  = ex_mem_read_q;
  assign ExMemWrite = ex_mem_write_q;

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage -- self-checking bench for id_stage.
// A behavioural model (register array, IF/ID pair, expected ID/EX record) is
// advanced on every clock; a compare process checks all DUT outputs against it
// at every falling edge. Directed sequences add literal expectations, then
// randomized traffic (with occasional reset pulses) exercises the rest.
// Honours WB_BYPASS_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [29:0] PC = '0;
  logic [31:0] IR = '0;
  logic        IsStall, IsBranch;
  logic [29:0] BranchAddr;
  logic        WbEn = 1'b0;
  logic [4:0]  WbAddr = '0;
  logic [31:0] WbData = '0;
  logic [4:0]  MemRd = '0;
  logic        MemRegWrite = 1'b0;
  logic        ExValid;
  logic [29:0] ExPC;
  logic [3:0]  ExOp;
  logic [31:0] ExA, ExB, ExImm;
  logic [4:0]  ExRd;
  logic        ExRegWrite, ExMemRead, ExMemWrite;

  id_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .PC(PC), .IR(IR),
    .IsStall(IsStall), .IsBranch(IsBranch), .BranchAddr(BranchAddr),
    .WbEn(WbEn), .WbAddr(WbAddr), .WbData(WbData),
    .MemRd(MemRd), .MemRegWrite(MemRegWrite),
    .ExValid(ExValid), .ExPC(ExPC), .ExOp(ExOp), .ExA(ExA), .ExB(ExB),
    .ExImm(ExImm), .ExRd(ExRd), .ExRegWrite(ExRegWrite),
    .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        v;
    logic [29:0] pc;
    logic [3:0]  op;
    logic [31:0] a, b, imm;
    logic [4:0]  rd;
    logic        rw, mr, mw;
  } ex_t;

  logic [31:0] m_regs [32];
  logic [29:0] m_pc;
  logic [31:0] m_ir;
  ex_t         m_ex;

  function automatic logic [31:0] rf(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (WbEn && WbAddr == a) return WbData;
`endif
    return m_regs[a];
  endfunction

  task automatic model_eval(output logic stall, output logic br,
                            output logic [29:0] tgt, output ex_t nx);
    int unsigned op;
    logic [4:0]  rd, rs1, rs2;
    logic [4:0]  srcs[$];
    longint      t;
    op  = m_ir[31:26];
    rd  = m_ir[25:21];
    rs1 = m_ir[20:16];
    rs2 = m_ir[15:11];
    case (op)
      1:       srcs = '{rs1, rs2};
      2, 3:    srcs = '{rs1};
      4, 5:    srcs = '{rs1, rd};
      default: srcs = {};
    endcase
    stall = 1'b0;
    foreach (srcs[i]) begin
      if (m_ex.v && m_ex.mr && m_ex.rd != 0 && srcs[i] == m_ex.rd) stall = 1'b1;
      if (op == 5 && srcs[i] != 0 &&
          ((m_ex.rw && srcs[i] == m_ex.rd) || (MemRegWrite && srcs[i] == MemRd)))
        stall = 1'b1;
    end
    br  = 1'b0;
    tgt = '0;
    if (!stall && op == 6) begin
      br  = 1'b1;
      tgt = (m_pc & 30'h3C000000) | 30'(m_ir[25:0]);
    end
    if (!stall && op == 5 && rf(rd) == rf(rs1)) begin
      br  = 1'b1;
      t   = longint'(m_pc) + 1 + longint'($signed(m_ir[15:0]));
      tgt = t[29:0];
    end
    nx = '0;
    if (!stall && op >= 1 && op <= 6) begin
      nx.v   = 1'b1;
      nx.pc  = m_pc;
      nx.a   = rf(rs1);
      nx.b   = (op == 4 || op == 5) ? rf(rd) : rf(rs2);
      nx.imm = 32'($signed(m_ir[15:0]));
      nx.op  = (op == 1) ? m_ir[3:0] : 4'h0;
      nx.rw  = (op >= 1 && op <= 3);
      nx.mr  = (op == 3);
      nx.mw  = (op == 4);
      nx.rd  = nx.rw ? rd : 5'd0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin : model_step
    logic st, br;
    logic [29:0] tg;
    ex_t nx;
    if (!rst_n) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_pc = '0;
      m_ir = '0;
      m_ex = '0;
    end else begin
      model_eval(st, br, tg, nx);
      m_ex = nx;
      if (WbEn && WbAddr != 0) m_regs[WbAddr] = WbData;
      if (!st) begin
        m_pc = PC;
        m_ir = br ? 32'h0 : IR;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic st, br;
    logic [29:0] tg;
    ex_t nx;
    model_eval(st, br, tg, nx);
    chk("is_stall", IsStall, st);
    chk("is_branch", IsBranch, br);
    chk("branch_addr", BranchAddr, tg);
    chk("ex_bundle", {ExValid, ExPC, ExOp, ExA, ExB, ExImm, ExRd,
                      ExRegWrite, ExMemRead, ExMemWrite}, m_ex);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  localparam logic [31:0] NOP = 32'h0;
  logic        s_stall, s_br;
  logic [29:0] s_addr;

  function automatic logic [31:0] alu(input logic [4:0] rd, rs1, rs2, input logic [5:0] f);
    return {6'h01, rd, rs1, rs2, 5'd0, f};
  endfunction

  // Call at posedge+1: apply inputs, capture combinational outputs, clock once.
  task automatic drive(input logic [29:0] pc, input logic [31:0] ir, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
    PC = pc; IR = ir; WbEn = we; WbAddr = wa; WbData = wd;
    MemRd = 5'd0; MemRegWrite = 1'b0;
    #2;
    s_stall = IsStall; s_br = IsBranch; s_addr = BranchAddr;
    @(posedge clk); #1;
  endtask

  task automatic drive_rand();
    logic [31:0] ir;
    ir = $urandom;
    ir[31:26] = 6'($urandom_range(0, 8));
    ir[25:21] = 5'($urandom_range(0, 7));
    ir[20:16] = 5'($urandom_range(0, 7));
    ir[15:11] = 5'($urandom_range(0, 7));
    PC = 30'($urandom);
    IR = ir;
    WbEn = 1'($urandom_range(0, 1));
    WbAddr = 5'($urandom_range(0, 7));
    WbData = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
    MemRd = 5'($urandom_range(0, 7));
    MemRegWrite = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_exvalid", ExValid, 1'b0);
    chk("reset_stall", IsStall, 1'b0);
    rst_n = 1'b1;

    // r0 ignores writes
    drive(30'd0, NOP, 1'b1, 5'd0, 32'h1234);
    drive(30'd1, alu(5'd4, 5'd0, 5'd0, 6'd0), 1'b0, 5'd0, 32'h0);
    drive(30'd2, NOP, 1'b0, 5'd0, 32'h0);
    chk("r0_read", ExA, 32'h0);
    chk("r0_valid", ExValid, 1'b1);

    // same-cycle write/read of r9
    drive(30'd3, NOP, 1'b1, 5'd9, 32'h11111111);
    drive(30'd4, alu(5'd10, 5'd9, 5'd0, 6'd0), 1'b0, 5'd0, 32'h0);
    drive(30'd5, NOP, 1'b1, 5'd9, 32'hDEADBEEF);
`ifdef WB_BYPASS_EN
    chk("bypass_read", ExA, 32'hDEADBEEF);
`else
    chk("bypass_read", ExA, 32'h11111111);
`endif
    drive(30'd6, alu(5'd11, 5'd9, 5'd0, 6'd0), 1'b0, 5'd0, 32'h0);
    drive(30'd7, NOP, 1'b0, 5'd0, 32'h0);
    chk("after_write_read", ExA, 32'hDEADBEEF);

    // load-use
    drive(30'd8, NOP, 1'b1, 5'd2, 32'd5);
    drive(30'd9, NOP, 1'b1, 5'd1, 32'd7);
    drive(30'h20, {6'h03, 5'd3, 5'd1, 16'h0004}, 1'b0, 5'd0, 32'h0);
    drive(30'h21, alu(5'd4, 5'd3, 5'd2, 6'd2), 1'b0, 5'd0, 32'h0);
    drive(30'h22, NOP, 1'b0, 5'd0, 32'h0);
    chk("lu_stall", s_stall, 1'b1);
    chk("lu_bubble", ExValid, 1'b0);
    drive(30'h23, NOP, 1'b0, 5'd0, 32'h0);
    chk("lu_release", s_stall, 1'b0);
    chk("lu_issue", {ExValid, ExRd, ExOp, ExB}, {1'b1, 5'd4, 4'd2, 32'd5});

    // BEQ taken, backward offset
    drive(30'h24, NOP, 1'b1, 5'd2, 32'd7);
    drive(30'h10, {6'h05, 5'd1, 5'd2, 16'hFFFE}, 1'b0, 5'd0, 32'h0);
    drive(30'h30, NOP, 1'b0, 5'd0, 32'h0);
    chk("beq_taken", s_br, 1'b1);
    chk("beq_addr", s_addr, 30'h0F);
    chk("beq_issue", {ExValid, ExRegWrite, ExMemRead, ExMemWrite}, 4'b1000);
    drive(30'h31, NOP, 1'b0, 5'd0, 32'h0);
    chk("beq_shadow", ExValid, 1'b0);

    // JMP with PC high bits
    drive(30'h3FFFFFFF, {6'h06, 26'h0000005}, 1'b0, 5'd0, 32'h0);
    drive(30'd0, NOP, 1'b0, 5'd0, 32'h0);
    chk("jmp_taken", s_br, 1'b1);
    chk("jmp_addr", s_addr, 30'h3C000005);

    // reset in the middle of a stall
    drive(30'd1, NOP, 1'b1, 5'd5, 32'hAB);
    drive(30'd2, {6'h03, 5'd3, 5'd0, 16'h0000}, 1'b0, 5'd0, 32'h0);
    drive(30'd3, alu(5'd6, 5'd3, 5'd0, 6'd0), 1'b0, 5'd0, 32'h0);
    #2;
    chk("pre_reset_stall", IsStall, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_stall", IsStall, 1'b0);
    chk("rst_branch", {IsBranch, BranchAddr}, 31'h0);
    chk("rst_ex", {ExValid, ExPC, ExOp, ExA, ExB, ExImm, ExRd,
                   ExRegWrite, ExMemRead, ExMemWrite}, 160'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(30'd4, alu(5'd7, 5'd5, 5'd0, 6'd0), 1'b0, 5'd0, 32'h0);
    drive(30'd5, NOP, 1'b0, 5'd0, 32'h0);
    chk("r5_after_reset", ExA, 32'h0);
    chk("post_reset_issue", {ExValid, ExPC}, {1'b1, 30'd4});

    // randomized traffic with occasional reset pulses
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 60) == 0) begin
        rst_n = 1'b0;
        drive_rand();
        rst_n = 1'b1;
      end else begin
        drive_rand();
      end
    end

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
